// File: rtl/counter_7seg_if.sv
// Switch/display bundle for counter_7seg.
//   sw  : control switches, driven by the board side (master)
//   seg : active-low seven-segment pattern plus dp, driven by the counter (slave)
interface counter_7seg_if;
    logic [7:0] sw;
    logic [7:0] seg;

    modport master (output sw, input seg);
    modport slave  (input sw, output seg);
endinterface

// File: rtl/counter_7seg.sv
// Switch-controlled hexadecimal counter driving one seven-segment digit.
// A prescaler divides clk down to a count tick. Load and clear override
// counting, and the dp lights for the tick period following a wrap.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   bus.sw   : [0] run, [1] down, [2] clear, [3] load, [7:4] load value
//   bus.seg  : registered active-low segments {dp,g,f,e,d,c,b,a}
module counter_7seg #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    counter_7seg_if.slave  bus
);

    localparam logic [CNT_W-1:0] PMax = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] p_q, p_d;
    logic [3:0]       d_q, d_d;
    logic             w_q, w_d;
    logic [7:0]       seg_q, seg_d;
    logic [6:0]       hex;

    // Next-state: load beats clear beats run; hold resets the prescaler phase.
    always_comb begin
        p_d = p_q;
        d_d = d_q;
        w_d = w_q;
        if (bus.sw[3]) begin
            d_d = bus.sw[7:4];
            p_d = '0;
            w_d = 1'b0;
        end else if (bus.sw[2]) begin
            d_d = 4'h0;
            p_d = '0;
            w_d = 1'b0;
        end else if (bus.sw[0]) begin
            if (p_q == PMax) begin
                p_d = '0;
                if (bus.sw[1]) begin
                    d_d = d_q - 4'h1;
                    w_d = (d_q == 4'h0);
                end else begin
                    d_d = d_q + 4'h1;
                    w_d = (d_q == 4'hF);
                end
            end else begin
                p_d = p_q + 1'b1;
            end
        end else begin
            p_d = '0;
        end
    end

    // Hex-to-segment decode of the current digit, active low {g,f,e,d,c,b,a}.
    always_comb begin
        hex = 7'h7F;
        unique case (d_q)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
        // Display follows the registered digit, so seg trails D by one cycle.
        seg_d = {~w_q, hex};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            d_q   <= 4'h0;
            w_q   <= 1'b0;
            seg_q <= 8'hC0;
        end else begin
            p_q   <= p_d;
            d_q   <= d_d;
            w_q   <= w_d;
            seg_q <= seg_d;
        end
    end

    assign bus.seg = seg_q;

endmodule

// File: tb/tb_counter_7seg.sv
module tb_counter_7seg;

    localparam int PRESCALE = 4;

    logic clk;
    logic rst;

    counter_7seg_if bus ();

    counter_7seg #(
        .PRESCALE (PRESCALE),
        .CNT_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference patterns for digits 0..F, dp off.
    logic [7:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 8'hC0; seg_tab[1]  = 8'hF9; seg_tab[2]  = 8'hA4; seg_tab[3]  = 8'hB0;
        seg_tab[4]  = 8'h99; seg_tab[5]  = 8'h92; seg_tab[6]  = 8'h82; seg_tab[7]  = 8'hF8;
        seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
        seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;
    end

    // Behavioural model: integer digit, phase count and wrap flag.
    int m_digit;
    int m_phase;
    bit m_wrap;

    logic [7:0] exp_q[$];
    int checks;
    int errors;
    int cyc;

    function automatic logic [7:0] show(input int digit, input bit wrap);
        logic [7:0] v;
        v = seg_tab[digit];
        if (wrap) v = v & 8'h7F;
        return v;
    endfunction

    // Apply one cycle of inputs and predict seg after the coming edge.
    task automatic step(input logic r, input logic [7:0] s);
        @(negedge clk);
        rst    = r;
        bus.sw = s;
        if (r) exp_q.push_back(8'hC0);
        else   exp_q.push_back(show(m_digit, m_wrap));
        if (r) begin
            m_digit = 0; m_phase = 0; m_wrap = 0;
        end else if (s[3]) begin
            m_digit = int'(s[7:4]); m_phase = 0; m_wrap = 0;
        end else if (s[2]) begin
            m_digit = 0; m_phase = 0; m_wrap = 0;
        end else if (s[0]) begin
            m_phase = m_phase + 1;
            if (m_phase == PRESCALE) begin
                m_phase = 0;
                if (s[1]) begin
                    m_wrap  = (m_digit == 0);
                    m_digit = (m_digit + 15) % 16;
                end else begin
                    m_wrap  = (m_digit == 15);
                    m_digit = (m_digit + 1) % 16;
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic repeat_step(input int n, input logic [7:0] s);
        for (int i = 0; i < n; i++) step(1'b0, s);
    endtask

    // Monitor: seg is presented every cycle; compare against the oldest prediction.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++;
                if (bus.seg !== e) begin
                    errors++;
                    $display("FAIL seg cycle %0d: got %h expected %h", cyc, bus.seg, e);
                end
            end
        end
    end

    initial begin
        logic [7:0] s;
        checks  = 0;
        errors  = 0;
        m_digit = 0;
        m_phase = 0;
        m_wrap  = 0;
        rst     = 1'b1;
        bus.sw  = 8'h00;

        // Reset, then idle.
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        repeat_step(10, 8'h00);
        // Count up through every digit and across the wrap.
        repeat_step(PRESCALE * 18 + 2, 8'h01);
        // Clear, then count down through the wrap.
        step(1'b0, 8'h04);
        repeat_step(PRESCALE * 3 + 1, 8'h03);
        // Load priority over run, clear priority over run, hold.
        repeat_step(6, 8'hA9);
        repeat_step(3, 8'h05);
        repeat_step(2, 8'h31);
        repeat_step(PRESCALE + 1, 8'h01);
        repeat_step(3, 8'h00);
        repeat_step(PRESCALE * 2 + 1, 8'h01);
        // Direction change mid-period.
        repeat_step(2, 8'h01);
        repeat_step(PRESCALE * 2, 8'h03);
        // Reset mid-count with phase at 2.
        step(1'b0, 8'h04);
        repeat_step(2, 8'h01);
        step(1'b1, 8'h01);
        repeat_step(PRESCALE * 2 + 2, 8'h01);

        // Randomised: mostly run, occasional direction flips, rare load/clear/reset.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic rr;
            s  = 8'h00;
            r  = $urandom_range(0, 99);
            s[0] = (r < 85);
            s[1] = ($urandom_range(0, 9) < 4);
            s[2] = ($urandom_range(0, 99) < 2);
            s[3] = ($urandom_range(0, 99) < 2);
            s[7:4] = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 199) == 0);
            step(rr, s);
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_7seg.md
Name: counter_7seg

Overview:
- Switch-controlled 4-bit hexadecimal counter that drives a single seven-segment digit plus decimal point.
- Sits between board switches and an LED display.
- An internal prescaler divides clk to a slow count tick.
- Switches select run/hold, direction, clear and parallel load.

Parameters:
PRESCALE, 4, clk cycles per count tick (≥2); set large, e.g. 50_000_000, for hardware.
CNT_W, 32, prescaler register width; must hold PRESCALE-1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
sw   input  8  control switches: [0] run, [1] down (1=decrement), [2] clear, [3] load, [7:4] load value
seg  output 8  active-low segments: [6:0]={g,f,e,d,c,b,a}, [7]=dp; registered

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No other async logic. sw is used directly; no synchronizer or debounce inside the block.
- State: prescaler P (CNT_W bits), digit D (4 bits), wrap flag W (1 bit), output register seg.
- Reset (rst=1 at a clk edge): P=0, D=0, W=0, seg=8'hC0 (digit 0, dp off).
- Per-edge priority, highest first:
  1. rst.
  2. sw[3]=1: D=sw[7:4], P=0, W=0.
  3. sw[2]=1: D=0, P=0, W=0.
  4. sw[0]=1: if P==PRESCALE-1 then tick (P=0, step D) else P=P+1.
  5. sw[0]=0: P=0; D and W hold.
- Load and clear act every cycle they are held, whether or not sw[0] is set.
- Step on tick:
  - sw[1]=0: D=D+1 mod 16. W=1 if D was 4'hF, else W=0.
  - sw[1]=1: D=D-1 mod 16. W=1 if D was 4'h0, else W=0.
- Direction is sampled at the tick edge; changing sw[1] mid-period does not reset P.
- First tick lands on the PRESCALE-th consecutive edge with sw[0]=1 (from P=0). Later ticks follow every PRESCALE cycles.
- seg is registered from the post-update D and W. It lags D by exactly one clk cycle.
  - seg[6:0] = active-low hex pattern of D.
  - seg[7] = ~W (dp lit during the tick period right after a wrap).
- seg codes with dp off, for D = 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- dp lit clears bit 7; e.g. digit 0 with dp lit = 8'h40.
- Reset asserted mid-count discards the prescaler phase. The first post-reset tick needs a full PRESCALE run cycles.
- No X propagation: every register has a defined reset value.

Test Plan:
1. Reset only:
   - rst=1 for 2 cycles, sw=0 -> seg=8'hC0.
   - seg holds 8'hC0 indefinitely with sw=0 after rst drops.
2. Count up (PRESCALE=4):
   - sw=8'h01 after reset -> D becomes 1 on the 4th edge, seg=8'hF9 one cycle later.
   - D=2 (seg=8'hA4) 4 cycles after that.
   - Sequence continues through 8'h8E.
3. Wrap up:
   - After D=F, next tick -> D=0, seg=8'h40 (dp lit).
   - Following tick -> D=1, seg=8'hF9 (dp off).
4. Count down and wrap:
   - From D=0, sw=8'h03 -> after 4 cycles D=F, seg=8'h0E (dp lit).
   - Next tick -> D=E, seg=8'h86.
5. Load/clear priority and hold:
   - sw=8'hA9 (load 0xA, run) -> seg=8'h88, D stays A while sw[3]=1.
   - sw=8'h05 (clear+run) -> seg=8'hC0.
   - sw=8'h00 -> D holds, P restarts from 0 when run resumes.
6. Reset mid-operation:
   - While counting with P=2, pulse rst one cycle -> seg=8'hC0 next cycle.
   - First tick then needs 4 full run cycles.
